// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction prefetch queue: default depth and
// reset PC, the NOP encoding and the packed {inst, pc4} queue entry.
package pipe_pkg;

   localparam int          PFQ_DEPTH    = 4;
   localparam logic [31:0] PFQ_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } pfq_entry_t;

   // Sequential fetch step; wraps 32'hFFFF_FFFC -> 0 naturally.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pipe_prefetch_q_if.sv
// Fetch-side bus of the prefetch queue: decode controls, instruction memory
// handshake and the head-of-queue outputs. "master" is the queue itself,
// "slave" is the surrounding pipeline / memory.
interface pipe_prefetch_q_if;

   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        q_valid;
   logic [31:0] q_inst;
   logic [31:0] q_pc4;

   modport master (
      input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
      output imem_req, imem_addr, q_valid, q_inst, q_pc4
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_ready, imem_rdata,
      input  imem_req, imem_addr, q_valid, q_inst, q_pc4
   );

endinterface

// File: rtl/pipe_pfq_fifo.sv
// Circular entry store for the prefetch queue: DEPTH entries, wrapping
// read/write pointers, occupancy count with full/empty flags and a
// synchronous flush used by redirects.
module pipe_pfq_fifo
   import pipe_pkg::*;
#(
   parameter  int DEPTH = PFQ_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  pfq_entry_t    wdata,
   output pfq_entry_t    head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   pfq_entry_t      mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush returns to the empty state.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset: contents are only observed when count > 0.
   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/pipe_prefetch_q.sv
// Instruction prefetch queue feeding the IF/ID register. Owns the fetch PC,
// streams sequential word fetches while space remains, and presents the
// oldest buffered instruction with its PC+4. A redirect flushes everything
// and restarts fetching at the (word-aligned) target.
// Optional feature: define PIPE_PREFETCH_BYPASS_EN to forward a fetch
// straight to q_* when the queue is empty.
module pipe_prefetch_q
   import pipe_pkg::*;
#(
   parameter int          DEPTH    = PFQ_DEPTH,
   parameter logic [31:0] RESET_PC = PFQ_RESET_PC
) (
   input  logic               clock,
   input  logic               resetn,
   pipe_prefetch_q_if.master  bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic          accept;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          byp;
   logic [CW-1:0] count;
   pfq_entry_t    wdata;
   pfq_entry_t    head;

   assign bus.imem_req  = !full && !bus.redirect;
   assign bus.imem_addr = fetch_pc;
   assign accept        = bus.imem_req && bus.imem_ready;
   assign wdata         = '{inst: bus.imem_rdata, pc4: pc_next(fetch_pc)};

`ifdef PIPE_PREFETCH_BYPASS_EN
   // Empty queue: the returning word is shown directly and, if decode takes
   // it this cycle, never lands in storage.
   assign byp  = empty && accept;
   assign push = accept && !(byp && !bus.stall);
`else
   assign byp  = 1'b0;
   assign push = accept;
`endif
   assign pop = !empty && !bus.stall && !bus.redirect;

   // Head presentation; NOP and zero PC+4 whenever nothing real is held.
   always_comb begin
      bus.q_valid = 1'b0;
      bus.q_inst  = NOP_INST;
      bus.q_pc4   = 32'h0;
      if (!empty) begin
         bus.q_valid = 1'b1;
         bus.q_inst  = head.inst;
         bus.q_pc4   = head.pc4;
      end else if (byp) begin
         bus.q_valid = 1'b1;
         bus.q_inst  = wdata.inst;
         bus.q_pc4   = wdata.pc4;
      end
   end

   // Fetch PC: restart on redirect (word aligned), step on each accepted fetch.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)           fetch_pc <= RESET_PC;
      else if (bus.redirect) fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      else if (accept)       fetch_pc <= pc_next(fetch_pc);
   end

   pipe_pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .flush  (bus.redirect),
      .push   (push),
      .pop    (pop),
      .wdata  (wdata),
      .head   (head),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

endmodule

// File: tb/tb_pipe_prefetch_q.sv
// Self-checking bench for pipe_prefetch_q: directed scenarios followed by
// randomized traffic. The reference model is a plain queue of expected
// {inst, pc4} entries plus a fetch PC; the monitor compares DUT outputs
// against it on every falling edge.
module tb_pipe_prefetch_q;
   import pipe_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef PIPE_PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   int   nvec   = 0;
   int   nmis   = 0;

   pfq_entry_t  sb[$];
   logic [31:0] m_pc = RPC;

   pipe_prefetch_q_if bus();

   pipe_prefetch_q #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   // Memory image: every address returns a distinct word.
   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign bus.imem_rdata = memw(bus.imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advance for the cycle that just ended, using the inputs held over it.
   task automatic model_step();
      bit acc;
      bit consumed;
      if (!resetn) return;
      acc = (sb.size() < DEPTH) && !bus.redirect && bus.imem_ready;
      if (bus.redirect) begin
         sb.delete();
         m_pc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
         consumed = BYP && (sb.size() == 0) && acc && !bus.stall;
         if (sb.size() > 0 && !bus.stall) void'(sb.pop_front());
         if (acc && !consumed) sb.push_back('{inst: memw(m_pc), pc4: m_pc + 32'd4});
         if (acc) m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
      @(posedge clock);
      model_step();
      #1;
      bus.stall       = st;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      bus.imem_ready  = rdy;
   endtask

   task automatic run_n(input int n, input logic st, input logic rdy);
      for (int i = 0; i < n; i++) cycle(st, 1'b0, 32'h0, rdy);
   endtask

   // Monitor: compare every visible output against the model state.
   always @(negedge clock) begin
      bit          req;
      bit          acc;
      bit          vld;
      pfq_entry_t  e;
      req = (sb.size() < DEPTH) && !bus.redirect;
      acc = req && bus.imem_ready && resetn;
      vld = 1'b0;
      e   = '0;
      if (resetn && sb.size() > 0) begin
         vld = 1'b1;
         e   = sb[0];
      end else if (BYP && acc) begin
         vld = 1'b1;
         e   = '{inst: memw(m_pc), pc4: m_pc + 32'd4};
      end
      chk("imem_req", {31'h0, bus.imem_req}, {31'h0, req});
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("q_valid", {31'h0, bus.q_valid}, {31'h0, vld});
      chk("q_inst", bus.q_inst, e.inst);
      chk("q_pc4", bus.q_pc4, e.pc4);
   end

   initial begin
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.imem_ready  = 1'b0;
      #12 resetn = 1'b1;

      // Streaming fetch, no stall.
      run_n(12, 1'b0, 1'b1);
      // Long stall fills the queue, then release.
      run_n(6, 1'b1, 1'b1);
      run_n(8, 1'b0, 1'b1);
      // Redirect with three entries held (low address bits ignored).
      run_n(3, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1);
      run_n(4, 1'b0, 1'b1);
      // Redirect during stall, then memory not ready for three cycles.
      run_n(2, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 32'h0000_0010, 1'b1);
      run_n(3, 1'b0, 1'b0);
      run_n(4, 1'b0, 1'b1);
      // Address wrap at the top of memory.
      cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      run_n(6, 1'b0, 1'b1);

      // Asynchronous reset mid-fill with entries held.
      cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
      run_n(2, 1'b1, 1'b1);
      @(posedge clock);
      model_step();
      #1;
      resetn         = 1'b0;
      bus.stall      = 1'b0;
      bus.redirect   = 1'b0;
      bus.imem_ready = 1'b0;
      sb.delete();
      m_pc = RPC;
      #1;
      chk("rst_q_valid", {31'h0, bus.q_valid}, 32'h0);
      chk("rst_q_inst", bus.q_inst, NOP_INST);
      chk("rst_q_pc4", bus.q_pc4, 32'h0);
      @(posedge clock);
      #1 resetn = 1'b1;
      run_n(6, 1'b0, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic        st;
         logic        rd;
         logic        rdy;
         logic [31:0] rpc;
         st  = ($urandom_range(0, 99) < ((i / 500) % 2 ? 60 : 20));
         rdy = ($urandom_range(0, 99) < 75);
         rd  = ($urandom_range(0, 99) < 4);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         cycle(st, rd, rpc, rdy);
      end
      run_n(10, 1'b0, 1'b1);
      @(posedge clock);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/pipe_prefetch_q.md
# pipe_prefetch_q

Instruction prefetch queue that sits directly upstream of the IF/ID instruction register in the pipelined CPU. It owns the fetch PC, issues sequential word fetches to instruction memory through a req/ready handshake, and buffers returned instructions with their PC+4. It presents one instruction per cycle to the decode side and honours the ID-stage stall and branch/jump redirects.

## Interface
- DEPTH, 4, queue entries; power of two, minimum 2
- RESET_PC, 32'h0000_0000, fetch PC after reset
- clock  in  1  sole clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- stall  in  1  ID-stage interlock; holds the output entry
- redirect  in  1  taken branch/jump/jr; flush and refetch
- redirect_pc  in  32  new fetch address, valid with redirect
- imem_req  out  1  fetch request
- imem_addr  out  32  word address of request (fetch PC)
- imem_ready  in  1  memory accepts request; imem_rdata valid same cycle
- imem_rdata  in  32  fetched instruction
- q_valid  out  1  q_inst/q_pc4 hold a real instruction
- q_inst  out  32  head instruction; 32'h0 (NOP) when !q_valid
- q_pc4  out  32  head PC+4; 32'h0 when !q_valid

## Operation
- State: fetch_pc (32), DEPTH×{inst, pc4} storage, rd_ptr/wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- imem_req = (count < DEPTH) && !redirect; imem_addr = fetch_pc.
- Push when imem_req && imem_ready: store {imem_rdata, fetch_pc+4}; fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
- Pop when q_valid && !stall: rd_ptr advances.
- Push and pop same cycle: count unchanged, both pointers advance.
- Full (count==DEPTH): imem_req low, no push; pop frees one slot, req rises next cycle.
- Empty: q_valid=0, q_inst=q_pc4=0; stall has no effect.
- redirect (priority over everything): count, rd_ptr, wr_ptr cleared, fetch_pc <= redirect_pc, no push, no pop that cycle; imem_ready in that cycle ignored.
- redirect during stall: still flushes; stalled head discarded.
- Reset (any time, incl. mid-transfer): fetch_pc=RESET_PC, count=0, pointers 0, q_valid=0, q_inst=0, q_pc4=0, imem_req=1 once resetn high.
- redirect_pc low two bits ignored (forced 00).

## Timing
- Request held with constant address until imem_ready; address changes only after accept or redirect.
- Fetch-to-output latency: 1 cycle (pushed at edge N, visible at q_* after edge N).
- Redirect at cycle N: new address requested at N+1; first new instruction on q_* at N+2 (N+1 with bypass).
- Throughput: one instruction/cycle sustained when imem_ready constantly high and no stall.
- Outputs q_* driven from registered storage/head only (no combinational path from imem_* unless bypass enabled).

## Configuration
- PIPE_PREFETCH_BYPASS_EN defined: when count==0 and a push occurs, imem_rdata/fetch_pc+4 drive q_* combinationally that cycle with q_valid=1; if !stall the entry is consumed and not written (count stays 0).
- Undefined: no bypass; empty-queue data always appears one cycle later.

## Structure
- Shared package pipe_pkg: PFQ_DEPTH default, RESET_PC default, NOP_INST=32'h0, packed entry type {inst[31:0], pc4[31:0]}.
- One sub-module: pipe_pfq_fifo (storage, pointers, count, full/empty); top level holds fetch_pc, handshake, redirect and bypass logic.

## Test plan
- Reset, imem_ready=1, no stall -> imem_addr 0,4,8,...; q_pc4 4,8,12 one cycle behind; q_valid=1 from second cycle.
- stall held 6 cycles, DEPTH=4 -> count reaches 4, imem_req drops, q_inst unchanged; release -> req rises next cycle, no instruction lost or duplicated.
- redirect_pc=32'h0000_0100 while queue holds 3 entries -> q_valid=0 next cycle, imem_addr=0x100, then q_pc4=0x104.
- imem_ready low 3 cycles on addr 0x10 -> imem_addr stays 0x10, imem_req stays high, queue drains to q_valid=0.
- redirect_pc=32'hFFFF_FFFC -> next fetches 0xFFFF_FFFC, 0x0; q_pc4 0x0 then 0x4.
- resetn asserted mid-fill with 2 entries -> immediately q_valid=0, q_inst=0, q_pc4=0, count 0; after release imem_addr=RESET_PC.
